reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard_pkg.sv | 10 +
 rtl/reg_scoreboard_if.sv | 46 ++++
 rtl/reg_scoreboard_entry.sv | 26 ++
 rtl/reg_scoreboard.sv | 55 +++++
 tb/tb_reg_scoreboard.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the register busy scoreboard: address and counter widths.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int CNT_W      = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      avail_cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/lookup bundle between the issue stage (master) and the scoreboard (slave).
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic       flush;
    logic       issue_valid_1;
    logic       issue_valid_2;
    logic       write_enable_signal_1;
    logic       write_enable_signal_2;
    reg_addr_t  write_reg_addr_1;
    reg_addr_t  write_reg_addr_2;
    avail_cnt_t latency_1;
    avail_cnt_t latency_2;
    reg_addr_t  addr_reg_1;
    reg_addr_t  addr_reg_2;
    reg_addr_t  addr_reg_3;
    reg_addr_t  addr_reg_4;
    reg_addr_t  addr_reg_5;
    reg_addr_t  addr_reg_6;
    avail_cnt_t avaiable_counter_1;
    avail_cnt_t avaiable_counter_2;
    avail_cnt_t avaiable_counter_3;
    avail_cnt_t avaiable_counter_4;
    avail_cnt_t avaiable_counter_5;
    avail_cnt_t avaiable_counter_6;
    logic       any_busy;

    modport master (
        output flush, issue_valid_1, issue_valid_2,
               write_enable_signal_1, write_enable_signal_2,
               write_reg_addr_1, write_reg_addr_2, latency_1, latency_2,
               addr_reg_1, addr_reg_2, addr_reg_3, addr_reg_4, addr_reg_5, addr_reg_6,
        input  avaiable_counter_1, avaiable_counter_2, avaiable_counter_3,
               avaiable_counter_4, avaiable_counter_5, avaiable_counter_6, any_busy
    );

    modport slave (
        input  flush, issue_valid_1, issue_valid_2,
               write_enable_signal_1, write_enable_signal_2,
               write_reg_addr_1, write_reg_addr_2, latency_1, latency_2,
               addr_reg_1, addr_reg_2, addr_reg_3, addr_reg_4, addr_reg_5, addr_reg_6,
        output avaiable_counter_1, avaiable_counter_2, avaiable_counter_3,
               avaiable_counter_4, avaiable_counter_5, avaiable_counter_6, any_busy
    );

endinterface

// File: rtl/reg_scoreboard_entry.sv
// One availability counter: loaded with a latency, then counts down to zero and stays there.
module scoreboard_entry #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt
);

    // Flush beats load, load beats decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: write-port decode into per-entry loads,
// six combinational lookup muxes and a global busy flag.
module reg_scoreboard #(
    parameter int NUM_REGS    = 128,
    parameter int CNT_W       = 4,
    parameter int ZERO_REG_RO = 1
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  bus
);
    import reg_scoreboard_pkg::*;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic             sel_1;
            logic             sel_2;
            logic             load;
            logic [CNT_W-1:0] load_val;

            assign sel_1 = bus.issue_valid_1 && bus.write_enable_signal_1
                           && (bus.write_reg_addr_1 == reg_addr_t'(gi));
            assign sel_2 = bus.issue_valid_2 && bus.write_enable_signal_2
                           && (bus.write_reg_addr_2 == reg_addr_t'(gi));
            // Register 0 is hardwired ready when read-only; otherwise either slot may load it.
            assign load     = (sel_1 || sel_2) && !((ZERO_REG_RO != 0) && (gi == 0));
            // Slot 2 is younger in program order, so its latency wins on a collision.
            assign load_val = sel_2 ? bus.latency_2 : bus.latency_1;

            scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
                .clk      (clk),
                .reset    (reset),
                .load     (load),
                .load_val (load_val),
                .flush    (bus.flush),
                .cnt      (cnt[gi])
            );

            assign busy[gi] = |cnt[gi];
        end
    endgenerate

    // Lookups read current state only; same-cycle issues are not bypassed.
    assign bus.avaiable_counter_1 = cnt[bus.addr_reg_1];
    assign bus.avaiable_counter_2 = cnt[bus.addr_reg_2];
    assign bus.avaiable_counter_3 = cnt[bus.addr_reg_3];
    assign bus.avaiable_counter_4 = cnt[bus.addr_reg_4];
    assign bus.avaiable_counter_5 = cnt[bus.addr_reg_5];
    assign bus.avaiable_counter_6 = cnt[bus.addr_reg_6];
    assign bus.any_busy           = |busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: the driver pushes expected lookups computed from a deadline model,
// a monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_scoreboard_if bus ();

    reg_scoreboard #(.NUM_REGS(128), .CNT_W(4), .ZERO_REG_RO(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0][6:0] addr;
        logic [5:0][3:0] cnt;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];

    // Model: each register becomes ready at an absolute edge number (its deadline);
    // its counter is simply how many edges remain until then.
    int deadline [128];
    int edges  = 0;
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    function automatic int model_val(int r);
        int d;
        d = deadline[r] - edges;
        return (d > 0) ? d : 0;
    endfunction

    function automatic logic [3:0] port_val(int k);
        case (k)
            0: return bus.avaiable_counter_1;
            1: return bus.avaiable_counter_2;
            2: return bus.avaiable_counter_3;
            3: return bus.avaiable_counter_4;
            4: return bus.avaiable_counter_5;
            5: return bus.avaiable_counter_6;
            default: return 4'd0;
        endcase
    endfunction

    task automatic step(input logic iv1, input logic we1, input logic [6:0] wa1, input logic [3:0] l1,
                        input logic iv2, input logic we2, input logic [6:0] wa2, input logic [3:0] l2,
                        input logic fl, input logic [5:0][6:0] a);
        exp_t e;
        logic any;
        @(negedge clk);
        bus.issue_valid_1 = iv1;
        bus.write_enable_signal_1 = we1;
        bus.write_reg_addr_1 = wa1;
        bus.latency_1 = l1;
        bus.issue_valid_2 = iv2;
        bus.write_enable_signal_2 = we2;
        bus.write_reg_addr_2 = wa2;
        bus.latency_2 = l2;
        bus.flush = fl;
        bus.addr_reg_1 = a[0];
        bus.addr_reg_2 = a[1];
        bus.addr_reg_3 = a[2];
        bus.addr_reg_4 = a[3];
        bus.addr_reg_5 = a[4];
        bus.addr_reg_6 = a[5];
        e.addr = a;
        for (int k = 0; k < 6; k++) e.cnt[k] = 4'(model_val(int'(a[k])));
        any = 1'b0;
        for (int r = 0; r < 128; r++) if (model_val(r) > 0) any = 1'b1;
        e.busy = any;
        exp_q.push_back(e);
        // Effect of the coming edge
        if (!reset) begin
            if (fl) begin
                for (int r = 0; r < 128; r++) deadline[r] = 0;
            end else begin
                if (iv1 && we1 && wa1 != 7'd0) deadline[wa1] = edges + 1 + int'(l1);
                if (iv2 && we2 && wa2 != 7'd0) deadline[wa2] = edges + 1 + int'(l2);
            end
        end
        edges++;
    endtask

    task automatic idle(input logic [5:0][6:0] a);
        step(1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, a);
    endtask

    // Monitor: compare every pushed expectation shortly after the inputs settle.
    initial begin
        exp_t e;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 6; k++) begin
                    got = port_val(k);
                    checks++;
                    if (got !== e.cnt[k]) begin
                        errors++;
                        $display("FAIL counter_%0d addr=%0d got=%0d expected=%0d", k + 1, e.addr[k], got, e.cnt[k]);
                    end
                end
                checks++;
                if (bus.any_busy !== e.busy) begin
                    errors++;
                    $display("FAIL any_busy got=%0b expected=%0b", bus.any_busy, e.busy);
                end
                $display("txn %0d: addr=%0d/%0d/%0d/%0d/%0d/%0d cnt=%0d/%0d/%0d/%0d/%0d/%0d busy=%0b",
                         txn, e.addr[0], e.addr[1], e.addr[2], e.addr[3], e.addr[4], e.addr[5],
                         e.cnt[0], e.cnt[1], e.cnt[2], e.cnt[3], e.cnt[4], e.cnt[5], e.busy);
                txn++;
            end
        end
    end

    initial begin
        logic [5:0][6:0] w;
        logic [5:0][6:0] w2;
        logic [5:0][6:0] ra;
        int waited;
        for (int r = 0; r < 128; r++) deadline[r] = 0;
        bus.flush = 1'b0;
        bus.issue_valid_1 = 1'b0;
        bus.issue_valid_2 = 1'b0;
        bus.write_enable_signal_1 = 1'b0;
        bus.write_enable_signal_2 = 1'b0;
        bus.write_reg_addr_1 = '0;
        bus.write_reg_addr_2 = '0;
        bus.latency_1 = '0;
        bus.latency_2 = '0;
        bus.addr_reg_1 = '0;
        bus.addr_reg_2 = '0;
        bus.addr_reg_3 = '0;
        bus.addr_reg_4 = '0;
        bus.addr_reg_5 = '0;
        bus.addr_reg_6 = '0;

        w  = {7'd3, 7'd0, 7'd30, 7'd20, 7'd12, 7'd7};
        w2 = {7'd20, 7'd12, 7'd7, 7'd50, 7'd40, 7'd3};

        // Reset held, then released; spread lookups read zero.
        idle(w);
        idle({7'd21, 7'd17, 7'd13, 7'd9, 7'd5, 7'd1});
        reset = 1'b0;
        idle({7'd21, 7'd17, 7'd13, 7'd9, 7'd5, 7'd1});

        // r7 latency 3 from slot 1
        step(1'b1, 1'b1, 7'd7, 4'd3, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, w);
        repeat (5) idle(w);

        // Both slots write r12: slot 2 latency wins
        step(1'b1, 1'b1, 7'd12, 4'd5, 1'b1, 1'b1, 7'd12, 4'd2, 1'b0, w);
        repeat (4) idle(w);

        // r20 at 4, reloaded with 9 two cycles later
        step(1'b0, 1'b0, 7'd0, 4'd0, 1'b1, 1'b1, 7'd20, 4'd4, 1'b0, w);
        idle(w);
        step(1'b1, 1'b1, 7'd20, 4'd9, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, w);
        repeat (3) idle(w);

        // Stalled slot must not load; r0 is read-only
        step(1'b0, 1'b1, 7'd30, 4'd6, 1'b1, 1'b1, 7'd0, 4'd5, 1'b0, w);
        repeat (2) idle(w);

        // Flush overrides a same-cycle load
        step(1'b1, 1'b1, 7'd3, 4'd8, 1'b1, 1'b1, 7'd40, 4'd9, 1'b0, w2);
        idle(w2);
        step(1'b1, 1'b1, 7'd50, 4'd7, 1'b0, 1'b0, 7'd0, 4'd0, 1'b1, w2);
        repeat (2) idle(w2);

        // Latency 0 loads ready immediately
        step(1'b1, 1'b1, 7'd3, 4'd0, 1'b1, 1'b1, 7'd40, 4'd15, 1'b0, w2);
        repeat (2) idle(w2);

        // Async reset mid-countdown, asserted between edges
        step(1'b1, 1'b1, 7'd3, 4'd10, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, w2);
        repeat (2) idle(w2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int r = 0; r < 128; r++) deadline[r] = 0;
        idle(w2);
        idle(w2);
        reset = 1'b0;
        idle(w2);

        // Randomized traffic on a small register window to force collisions
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 6; k++) ra[k] = 7'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 31) == 0), ra);
        end

        // Drain the expectation queue with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            #5;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
